// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default address map constants,
// reused by the bus master and the future APB slave peripherals.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_BASE_ADDR_DEF = 32'h1000_0000;
  localparam int          APB_SLV_SHIFT_DEF = 12;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int apb_idx_width(input int num_slv);
    if (num_slv > 1) begin
      return $clog2(num_slv);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: CPU byte address to one-hot slave select,
// binary slave index and a hit flag for the mapped window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLV   = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(APB_BASE_ADDR_DEF),
  parameter int                SLV_SHIFT = APB_SLV_SHIFT_DEF,
  localparam int               IDX_W     = apb_idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               hit_o
);

  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] region_s;
  logic              above_base_s;

  assign offset_s     = addr_i - BASE_ADDR;
  assign region_s     = offset_s >> SLV_SHIFT;
  // Addresses below the base wrap around in the subtraction, so reject them explicitly.
  assign above_base_s = (addr_i >= BASE_ADDR);
  assign hit_o        = above_base_s && (region_s < ADDR_W'(NUM_SLV));
  assign idx_o        = region_s[IDX_W-1:0];

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_sel
    assign sel_o[g] = hit_o && (region_s == ADDR_W'(g));
  end

endmodule

// File: rtl/apb_bus_master.sv
// APB bus master between the CPU data port and NUM_SLV peripherals: decodes the
// address, runs SETUP/ACCESS with wait states and a saturating timeout.
module apb_bus_master
  import apb_pkg::*;
#(
  parameter int                NUM_SLV     = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(APB_BASE_ADDR_DEF),
  parameter int                SLV_SHIFT   = APB_SLV_SHIFT_DEF,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            transfer,
  input  logic                            busWe,
  input  logic [ADDR_W-1:0]               busAddr,
  input  logic [DATA_W-1:0]               busWData,
  output logic [DATA_W-1:0]               busRData,
  output logic                            ready,
  output logic                            error,
  output logic [ADDR_W-1:0]               PADDR,
  output logic                            PWRITE,
  output logic                            PENABLE,
  output logic [DATA_W-1:0]               PWDATA,
  output logic [NUM_SLV-1:0]              PSEL,
  input  logic [NUM_SLV-1:0][DATA_W-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]              PREADY
);

  localparam int             IDX_W   = apb_idx_width(NUM_SLV);
  localparam int             CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  apb_state_e          state_q,   state_d;
  logic [NUM_SLV-1:0]  psel_q,    psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q,   paddr_d;
  logic                pwrite_q,  pwrite_d;
  logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                ready_q,   ready_d;
  logic                error_q,   error_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;

  logic [NUM_SLV-1:0]  dec_sel_s;
  logic [IDX_W-1:0]    dec_idx_s;
  logic                dec_hit_s;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_decoder (
    .addr_i (busAddr),
    .sel_o  (dec_sel_s),
    .idx_o  (dec_idx_s),
    .hit_o  (dec_hit_s)
  );

  // Next-state and output-register logic; ready/error/busRData default to a
  // one-cycle pulse that is only raised on the completing transition.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    rdata_d   = '0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = busAddr;
          pwrite_d = busWe;
          pwdata_d = busWData;
          cnt_d    = '0;
          if (dec_hit_s) begin
            psel_d    = dec_sel_s;
            idx_d     = dec_idx_s;
            penable_d = 1'b0;
            state_d   = SETUP;
          end else begin
            ready_d = 1'b1;
            error_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY[idx_q]) begin
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? '0 : PRDATA[idx_q];
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_TO)) begin
          ready_d   = 1'b1;
          error_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busRData = rdata_q;
  assign ready    = ready_q;
  assign error    = error_q;
  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PENABLE  = penable_q;
  assign PWDATA   = pwdata_q;
  assign PSEL     = psel_q;

endmodule
